// File: rtl/scarv_cop_dispatch.sv
// -----------------------------------------------------------------------------
// scarv_cop_dispatch
//
// Buffers coprocessor instructions issued by the core in a small FIFO,
// hands them one at a time to the coprocessor over a req/ack handshake,
// collects the coprocessor writeback into a single-entry response buffer and
// presents it to the core over a valid/ready handshake. At most one
// instruction is in flight between request acceptance and result retirement.
//
// Ports
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   iss_valid/iss_ready        core -> FIFO push handshake
//   iss_enc, iss_rs1           instruction encoding and RS1 operand
//   cpu_insn_req/cop_insn_ack  request to the coprocessor (registered)
//   cpu_insn_enc, cpu_rs1      head instruction presented with the request
//   cop_insn_rsp/cpu_insn_ack  coprocessor result handshake
//   cop_wen/waddr/wdata/result coprocessor writeback fields
//   rsp_valid/rsp_ready        buffered result handshake towards the core
//   rsp_wen/waddr/wdata/result buffered writeback fields
//   flush                      drop queued instructions not yet requested
//   insn_count                 retired-instruction counter (wraps)
//
// Parameter
//   DEPTH                      FIFO entries, power of two in 2..16
// -----------------------------------------------------------------------------
module scarv_cop_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [31:0] iss_enc,
    input  logic [31:0] iss_rs1,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    input  logic        cop_insn_rsp,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    output logic        cpu_insn_ack,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wen,
    output logic [4:0]  rsp_waddr,
    output logic [31:0] rsp_wdata,
    output logic [2:0]  rsp_result,
    input  logic        flush,
    output logic [31:0] insn_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    // Pointers are exactly log2(DEPTH) bits wide, so the natural overflow
    // of the increment is the modulo-DEPTH wrap.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        ptr_inc = ptr + PW'(1'b1);
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_ptr_s;
    logic          ready_r;
    logic [63:0]   fifo_mem_r [DEPTH];

    logic          req_r;
    logic [31:0]   enc_r;
    logic [31:0]   rs1_r;
    logic          ack_r;
    logic          rsp_valid_r;
    logic          rsp_wen_r;
    logic [4:0]    rsp_waddr_r;
    logic [31:0]   rsp_wdata_r;
    logic [2:0]    rsp_result_r;
    logic [31:0]   insn_count_r;

    logic          push_s;
    logic          pop_s;
    logic          rsp_fire_s;
    logic          ret_fire_s;
    logic          fifo_empty_s;
    logic          enter_req_s;
    logic [63:0]   head_s;

    // The registered not-full flag is low during reset; flush masks it so a
    // push offered together with a flush is never accepted.
    assign iss_ready    = ready_r & ~flush;
    assign cpu_insn_req = req_r;
    assign cpu_insn_enc = enc_r;
    assign cpu_rs1      = rs1_r;
    assign cpu_insn_ack = ack_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_wen      = rsp_wen_r;
    assign rsp_waddr    = rsp_waddr_r;
    assign rsp_wdata    = rsp_wdata_r;
    assign rsp_result   = rsp_result_r;
    assign insn_count   = insn_count_r;

    // Handshake qualifiers derived from the current state.
    always_comb begin
        fifo_empty_s = (count_r == CNT_ZERO);
        push_s       = iss_valid & iss_ready;
        pop_s        = (state_r == ST_REQ)  & cop_insn_ack;
        rsp_fire_s   = (state_r == ST_WAIT) & cop_insn_rsp;
        ret_fire_s   = (state_r == ST_RSP)  & rsp_ready;
        head_s       = fifo_mem_r[rd_ptr_r];
    end

    // Next-state logic. A flush seen while idle (or while retiring) wins over
    // starting a new request, because the queued entries are being dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !flush) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cop_insn_ack) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (cop_insn_rsp) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (!fifo_empty_s && !flush) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        enter_req_s = (state_s == ST_REQ) && (state_r != ST_REQ);
    end

    // FIFO pointer and occupancy update. In REQ the head is already being
    // requested, so a flush keeps exactly that entry (or nothing if it is
    // popped in the same cycle) and rewinds the tail to just behind it.
    always_comb begin
        count_s  = count_r;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        if (pop_s) begin
            rd_ptr_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        if (flush) begin
            if (state_r == ST_REQ) begin
                wr_ptr_s = ptr_inc(rd_ptr_r);
                if (pop_s) begin
                    count_s = CNT_ZERO;
                end else begin
                    count_s = CNT_ONE;
                end
            end else begin
                wr_ptr_s = rd_ptr_r;
                count_s  = CNT_ZERO;
            end
        end else begin
            if (push_s) begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
    end

    // State, FIFO control and request/ack output registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            wr_ptr_r <= PW'(1'b0);
            rd_ptr_r <= PW'(1'b0);
            ready_r  <= 1'b0;
            req_r    <= 1'b0;
            ack_r    <= 1'b0;
            enc_r    <= 32'h0000_0000;
            rs1_r    <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            ready_r  <= (count_s != CNT_FULL);
            req_r    <= (state_s == ST_REQ);
            ack_r    <= (state_s == ST_WAIT);
            // REQ is only entered from IDLE or RSP, where no pop happens,
            // so the current head is the entry that will be requested.
            if (enter_req_s) begin
                enc_r <= head_s[63:32];
                rs1_r <= head_s[31:0];
            end else begin
                enc_r <= enc_r;
                rs1_r <= rs1_r;
            end
        end
    end

    // FIFO storage; only the tail slot is written on an accepted push.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 64'h0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {iss_enc, iss_rs1};
            end
        end
    end

    // Response buffer: captured on the coprocessor result handshake, held
    // stable until the core takes it. Result codes pass through untouched.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rsp_valid_r  <= 1'b0;
            rsp_wen_r    <= 1'b0;
            rsp_waddr_r  <= 5'd0;
            rsp_wdata_r  <= 32'h0000_0000;
            rsp_result_r <= 3'd0;
        end else begin
            if (rsp_fire_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_wen_r    <= cop_wen;
                rsp_waddr_r  <= cop_waddr;
                rsp_wdata_r  <= cop_wdata;
                rsp_result_r <= cop_result;
            end else if (ret_fire_s) begin
                rsp_valid_r  <= 1'b0;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            insn_count_r <= 32'h0000_0000;
        end else begin
            if (ret_fire_s) begin
                insn_count_r <= insn_count_r + 32'h0000_0001;
            end
        end
    end

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Self-checking bench for scarv_cop_dispatch: directed scenarios followed by
// randomized traffic, checked by a negedge monitor against a queue-based
// reference model of the dispatcher.
module tb_scarv_cop_dispatch;

    localparam int DEPTH = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [31:0] iss_enc = 32'h0;
    logic [31:0] iss_rs1 = 32'h0;
    logic        cpu_insn_req;
    logic        cop_insn_ack = 1'b0;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_insn_rsp = 1'b0;
    logic        cop_wen = 1'b0;
    logic [4:0]  cop_waddr = 5'd0;
    logic [31:0] cop_wdata = 32'h0;
    logic [2:0]  cop_result = 3'd0;
    logic        cpu_insn_ack;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wen;
    logic [4:0]  rsp_waddr;
    logic [31:0] rsp_wdata;
    logic [2:0]  rsp_result;
    logic        flush = 1'b0;
    logic [31:0] insn_count;

    always #5 g_clk = ~g_clk;

    scarv_cop_dispatch #(.DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_enc(iss_enc), .iss_rs1(iss_rs1),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_insn_rsp(cop_insn_rsp), .cop_wen(cop_wen), .cop_waddr(cop_waddr),
        .cop_wdata(cop_wdata), .cop_result(cop_result),
        .cpu_insn_ack(cpu_insn_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wen(rsp_wen), .rsp_waddr(rsp_waddr),
        .rsp_wdata(rsp_wdata), .rsp_result(rsp_result),
        .flush(flush), .insn_count(insn_count)
    );

    typedef struct packed { logic [31:0] enc; logic [31:0] rs1; } insn_t;
    typedef struct packed { logic wen; logic [4:0] waddr; logic [31:0] wdata; logic [2:0] result; } rsp_t;

    // Reference model: queued (not yet accepted by the COP) instructions,
    // expected buffered results, and the transaction phase
    // (0 = nothing in flight, 1 = awaiting COP result, 2 = result buffered).
    insn_t       exp_q[$];
    rsp_t        rsp_q[$];
    int          phase = 0;
    logic [31:0] exp_cnt = 32'h0;
    int          stall = 0;
    int          req_cycles = 0;
    int          req_fires = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks outputs against the model, then applies the events
    // that the upcoming rising edge will commit.
    always @(negedge g_clk) begin
        int    sz;
        logic  acc;
        insn_t h;
        if (!g_resetn) begin
            chk("rst_iss_ready", 32'(iss_ready), 32'd0);
            chk("rst_req", 32'(cpu_insn_req), 32'd0);
            chk("rst_ack", 32'(cpu_insn_ack), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_fields", 32'({rsp_wen, rsp_waddr, rsp_result, rsp_wdata != 32'h0}), 32'd0);
            chk("rst_insn_count", insn_count, 32'd0);
            exp_q.delete();
            rsp_q.delete();
            phase   = 0;
            exp_cnt = 32'h0;
            stall   = 0;
        end else begin
            sz = exp_q.size();
            chk("iss_ready", 32'(iss_ready), 32'(sz < DEPTH && !flush));
            chk("cpu_insn_ack", 32'(cpu_insn_ack), 32'(phase == 1));
            chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
            chk("insn_count", insn_count, exp_cnt);
            if (cpu_insn_req) begin
                req_cycles++;
                stall = 0;
                chk("req_legal", 32'(phase == 0 && sz > 0), 32'd1);
                if (sz > 0) begin
                    chk("req_enc", cpu_insn_enc, exp_q[0].enc);
                    chk("req_rs1", cpu_rs1, exp_q[0].rs1);
                end
            end else if (phase == 0 && sz > 0) begin
                stall++;
                chk("req_latency", 32'(stall <= 3), 32'd1);
            end else begin
                stall = 0;
            end
            if (rsp_valid && rsp_q.size() > 0) begin
                chk("rsp_wen", 32'(rsp_wen), 32'(rsp_q[0].wen));
                chk("rsp_waddr", 32'(rsp_waddr), 32'(rsp_q[0].waddr));
                chk("rsp_wdata", rsp_wdata, rsp_q[0].wdata);
                chk("rsp_result", 32'(rsp_result), 32'(rsp_q[0].result));
            end
            // events for the coming edge
            acc = iss_valid && !flush && (sz < DEPTH);
            if (flush) begin
                if (cpu_insn_req && exp_q.size() > 0) begin
                    h = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(h);
                end else begin
                    exp_q.delete();
                end
            end
            if (cpu_insn_req && cop_insn_ack) begin
                req_fires++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                phase = 1;
            end else if (phase == 1 && cop_insn_rsp) begin
                rsp_q.push_back('{wen: cop_wen, waddr: cop_waddr, wdata: cop_wdata, result: cop_result});
                phase = 2;
            end else if (phase == 2 && rsp_ready) begin
                if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                exp_cnt = exp_cnt + 32'd1;
                phase = 0;
            end
            if (acc) exp_q.push_back('{enc: iss_enc, rs1: iss_rs1});
        end
    end

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    // Randomized coprocessor / core-side behaviour, including result pulses
    // outside the wait window that the dispatcher must ignore.
    task automatic drive_cop_auto(input int pa, input int pr, input int prr);
        cop_insn_ack = ($urandom_range(99) < pa);
        if (cpu_insn_ack) cop_insn_rsp = ($urandom_range(99) < pr);
        else              cop_insn_rsp = ($urandom_range(99) < 10);
        cop_wen    = 1'($urandom_range(1));
        cop_waddr  = 5'($urandom_range(31));
        cop_wdata  = $urandom();
        cop_result = 3'($urandom_range(7));
        rsp_ready  = ($urandom_range(99) < prr);
    endtask

    task automatic drain(input string tag);
        int i = 0;
        iss_valid = 1'b0;
        flush     = 1'b0;
        while (i < 400 && !(exp_q.size() == 0 && phase == 0)) begin
            drive_cop_auto(60, 50, 70);
            step();
            i++;
        end
        cop_insn_ack = 1'b0;
        cop_insn_rsp = 1'b0;
        rsp_ready    = 1'b0;
        chk({tag, "_drained"}, 32'(exp_q.size() == 0 && phase == 0), 32'd1);
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        repeat (3) step();
        @(negedge g_clk);
        #1 g_resetn = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] c0, wd, e0, r0;
        int f0;

        do_reset();
        chk("post_reset_ready", 32'(iss_ready), 32'd1);

        // single instruction end to end
        req_cycles = 0;
        iss_valid = 1'b1; iss_enc = 32'h0000_102B; iss_rs1 = 32'h0000_1234;
        cop_insn_ack = 1'b1; rsp_ready = 1'b1;
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 20 && !cpu_insn_ack; i++) step();
        chk("t1_wait_entered", 32'(cpu_insn_ack), 32'd1);
        step();
        cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd3;
        cop_wdata = 32'h0000_CAFE; cop_result = 3'd0;
        step();
        cop_insn_rsp = 1'b0;
        for (int i = 0; i < 10 && !rsp_valid; i++) step();
        chk("t1_rsp_wdata", rsp_wdata, 32'h0000_CAFE);
        step();
        chk("t1_insn_count", insn_count, 32'd1);
        chk("t1_req_pulses", 32'(req_cycles), 32'd1);
        cop_insn_ack = 1'b0; rsp_ready = 1'b0;

        // request held stable under backpressure
        e0 = $urandom(); r0 = $urandom();
        iss_valid = 1'b1; iss_enc = e0; iss_rs1 = r0;
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 10 && !cpu_insn_req; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_req_held", 32'(cpu_insn_req), 32'd1);
            chk("t2_enc_held", cpu_insn_enc, e0);
            chk("t2_rs1_held", cpu_rs1, r0);
            step();
        end
        drain("t2");

        // fill to DEPTH, hold the extra push until one ack
        for (int i = 0; i < DEPTH; i++) begin
            iss_valid = 1'b1; iss_enc = 32'hA000_0000 + 32'(i); iss_rs1 = 32'(i);
            chk("t3_ready_filling", 32'(iss_ready), 32'd1);
            step();
        end
        iss_enc = 32'hA000_00FF; iss_rs1 = 32'h0000_00FF;
        for (int i = 0; i < 3; i++) begin
            chk("t3_ready_full", 32'(iss_ready), 32'd0);
            step();
        end
        cop_insn_ack = 1'b1;
        step();
        cop_insn_ack = 1'b0;
        chk("t3_ready_after_ack", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        chk("t3_refull", 32'(iss_ready), 32'd0);
        drain("t3");

        // flush while requesting with three queued
        c0 = exp_cnt; f0 = req_fires;
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1; iss_enc = 32'hB000_0000 + 32'(i); iss_rs1 = $urandom();
            step();
        end
        iss_valid = 1'b0;
        step();
        chk("t4_req_before_flush", 32'(cpu_insn_req), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain("t4");
        chk("t4_insn_count", insn_count, c0 + 32'd1);
        chk("t4_req_fires", 32'(req_fires - f0), 32'd1);

        // result stall
        iss_valid = 1'b1; iss_enc = $urandom(); iss_rs1 = $urandom();
        cop_insn_ack = 1'b1;
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 10 && !cpu_insn_ack; i++) step();
        wd = $urandom();
        cop_insn_rsp = 1'b1; cop_wdata = wd; cop_result = 3'd5; cop_wen = 1'b1; cop_waddr = 5'd17;
        step();
        cop_insn_rsp = 1'b0;
        iss_valid = 1'b1; iss_enc = $urandom(); iss_rs1 = $urandom();
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_ack_low", 32'(cpu_insn_ack), 32'd0);
            chk("t5_no_req", 32'(cpu_insn_req), 32'd0);
            chk("t5_wdata_held", rsp_wdata, wd);
            chk("t5_result_held", 32'(rsp_result), 32'd5);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t5_resume_req", 32'(cpu_insn_req), 32'd1);
        drain("t5");

        // reset while waiting for a result
        iss_valid = 1'b1; iss_enc = $urandom(); iss_rs1 = $urandom();
        cop_insn_ack = 1'b1;
        step();
        iss_valid = 1'b0;
        for (int i = 0; i < 10 && !cpu_insn_ack; i++) step();
        chk("t6_in_wait", 32'(cpu_insn_ack), 32'd1);
        g_resetn = 1'b0;
        #1;
        chk("t6_req_cleared", 32'(cpu_insn_req), 32'd0);
        chk("t6_ack_cleared", 32'(cpu_insn_ack), 32'd0);
        chk("t6_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("t6_count_cleared", insn_count, 32'd0);
        chk("t6_ready_low", 32'(iss_ready), 32'd0);
        cop_insn_ack = 1'b0;
        repeat (2) step();
        @(negedge g_clk);
        #1 g_resetn = 1'b1;
        step();
        cop_insn_rsp = 1'b1; cop_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_rsp_ignored", 32'(rsp_valid), 32'd0);
            chk("t6_count_zero", insn_count, 32'd0);
        end
        cop_insn_rsp = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            iss_valid = ($urandom_range(99) < 50);
            iss_enc   = $urandom();
            iss_rs1   = $urandom();
            flush     = ($urandom_range(99) < 3);
            drive_cop_auto(40, 40, 60);
            step();
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_cop_dispatch.md
SCARV_COP_DISPATCH -- requirements
Module: scarv_cop_dispatch

Interface
REQ-001 Parameter: DEPTH, 4, issue FIFO entries; power of two, 2..16.
REQ-002 g_clk  in  1  global clock; all state updates on rising edge.
REQ-003 g_resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 iss_valid  in  1  core offers a coprocessor instruction.
REQ-005 iss_ready  out  1  FIFO can accept an instruction.
REQ-006 iss_enc  in  32  encoded instruction from core.
REQ-007 iss_rs1  in  32  RS1 operand from core.
REQ-008 cpu_insn_req  out  1  instruction request to COP.
REQ-009 cop_insn_ack  in  1  COP accepts request.
REQ-010 cpu_insn_enc  out  32  encoding presented with request.
REQ-011 cpu_rs1  out  32  RS1 presented with request.
REQ-012 cop_insn_rsp  in  1  COP result valid.
REQ-013 cop_wen / cop_waddr / cop_wdata / cop_result  in  1/5/32/3  COP writeback and result code.
REQ-014 cpu_insn_ack  out  1  dispatcher accepts COP result.
REQ-015 rsp_valid  out  1  buffered result presented to core.
REQ-016 rsp_ready  in  1  core consumes result.
REQ-017 rsp_wen / rsp_waddr / rsp_wdata / rsp_result  out  1/5/32/3  buffered result fields.
REQ-018 flush  in  1  discard queued, not yet requested, instructions.
REQ-019 insn_count  out  32  retired-instruction counter.

Function
REQ-020 Issue push: iss_valid && iss_ready writes {iss_enc, iss_rs1} at FIFO tail; iss_ready = !full, no same-cycle bypass at full.
REQ-021 FSM states IDLE, REQ, WAIT, RSP; reset state IDLE.
REQ-022 IDLE -> REQ when FIFO non-empty; cpu_insn_req is a register output, high one cycle after entry becomes head.
REQ-023 In REQ: cpu_insn_req=1, cpu_insn_enc/cpu_rs1 driven from FIFO head, all three stable until cop_insn_ack sampled high.
REQ-024 REQ && cop_insn_ack: pop head, clear cpu_insn_req, -> WAIT; at most one instruction in flight.
REQ-025 In WAIT: cpu_insn_ack = 1; cop_insn_rsp captures cop_wen/waddr/wdata/result into response buffer, sets rsp_valid next cycle, -> RSP.
REQ-026 Response accepted in the same cycle cop_insn_rsp && cpu_insn_ack; cop_insn_rsp in REQ or IDLE is ignored.
REQ-027 In RSP: cpu_insn_ack = 0; rsp_valid=1 with fields stable until rsp_ready; rsp_valid && rsp_ready clears rsp_valid, increments insn_count, -> REQ if FIFO non-empty else IDLE.
REQ-028 insn_count wraps 0xFFFFFFFF -> 0.
REQ-029 Nonzero cop_result passed through unchanged; no retry, no state difference.
REQ-030 flush in IDLE/WAIT/RSP: FIFO emptied next cycle; in-flight instruction and buffered result unaffected.
REQ-031 flush in REQ: all entries except head discarded; head stays requested until acked (request never withdrawn).
REQ-032 flush && iss_valid same cycle: push suppressed, iss_ready forced 0.
REQ-033 Push and pop same cycle: count unchanged, both take effect; pointers wrap modulo DEPTH.

Reset
REQ-034 g_resetn low: FSM IDLE, FIFO empty, cpu_insn_req=0, cpu_insn_ack=0, rsp_valid=0, rsp fields 0, insn_count=0, iss_ready=0 while in reset, 1 first cycle after release.
REQ-035 Reset mid-transaction discards all queued, in-flight and buffered state; no output glitches beyond asynchronous clear.

Verification
REQ-036 Single insn: push enc=0x0000_102B rs1=0x1234, ack immediate, rsp 2 cycles later wdata=0xCAFE, rsp_ready=1 -> one req pulse, rsp_wdata=0xCAFE, insn_count=1.
REQ-037 Backpressure: cop_insn_ack low 5 cycles -> cpu_insn_req, cpu_insn_enc, cpu_rs1 stable all 5 cycles.
REQ-038 Full: push DEPTH+1 with ack low -> iss_ready=0 after 4th push (DEPTH=4), 5th held, accepted after first ack.
REQ-039 Flush in REQ with 3 queued -> head still acked and retired, other 2 never requested, insn_count=1.
REQ-040 Result stall: rsp_ready low 4 cycles -> cpu_insn_ack=0, no new req, rsp fields stable; resumes on rsp_ready.
REQ-041 Reset asserted in WAIT -> outputs per REQ-034 immediately, later cop_insn_rsp ignored, insn_count=0.
